// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared constants and types for the writeback register file / scoreboard.
package wb_regfile_scoreboard_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 2;

    // Largest number of writes that may be outstanding to one register
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

    // True when the index names a real (writable) register rather than x0
    function automatic logic is_arch_reg(input reg_idx_t idx);
        return (idx != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down with an error pulse
// on overflow (increment at max) or underflow (decrement at zero).
module wb_regfile_scoreboard_sb_counter
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W = wb_regfile_scoreboard_pkg::CNT_W
) (
    input  logic             stg_clk,
    input  logic             reset,
    input  logic             stg_ena,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err_pulse
);

    localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_s;

    // Next count; simultaneous inc and dec cancel, out-of-range moves hold and flag
    always_comb begin
        cnt_d = cnt_q;
        err_s = 1'b0;
        if (stg_ena) begin
            case ({inc, dec})
                2'b10: begin
                    if (cnt_q == CNT_TOP) begin
                        err_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_q == CNT_ZERO) begin
                        err_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge stg_clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign err_pulse = err_s;

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Writeback side of the ALU result latch: architectural register file with
// write-to-read bypass, per-register pending-write scoreboard and decode stall.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int XLEN     = wb_regfile_scoreboard_pkg::XLEN,
    parameter int NUM_REGS = wb_regfile_scoreboard_pkg::NUM_REGS,
    parameter int CNT_W    = wb_regfile_scoreboard_pkg::CNT_W
) (
    input  logic            stg_clk,
    input  logic            reset,
    input  logic            stg_ena,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_c,
    input  logic            wb_save,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_writes,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            sb_error
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]  regs_d [NUM_REGS];
    logic [XLEN-1:0]  regs_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_arr_s [NUM_REGS];
    logic [NUM_REGS-1:0] err_vec_s;

    logic wr_en_s;
    logic dec_s;
    logic inc_s;
    logic busy1_s;
    logic busy2_s;
    logic stall_s;
    logic sb_error_d;
    logic sb_error_q;

    // An operand is busy while writes are outstanding, unless the single
    // outstanding write lands this cycle and is forwarded on the bypass path
    function automatic logic operand_busy(
        input reg_idx_t         addr,
        input logic [CNT_W-1:0] cnt,
        input logic             dec,
        input reg_idx_t         dec_rd
    );
        logic bypassed;
        bypassed = (cnt == CNT_ONE) && dec && (dec_rd == addr);
        return is_arch_reg(addr) && (cnt != CNT_ZERO) && !bypassed;
    endfunction

    // Commit, scoreboard allocate and retire strobes
    always_comb begin
        wr_en_s = stg_ena && wb_save && is_arch_reg(wb_rd);
        dec_s   = wr_en_s;
        inc_s   = stg_ena && issue_valid && issue_writes && is_arch_reg(issue_rd) && !stall_s;
    end

    // Next register file contents; x0 is held at zero
    always_comb begin
        regs_d[0] = {XLEN{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            regs_d[r] = (wr_en_s && (wb_rd == REG_IDX_W'(r))) ? wb_c : regs_q[r];
        end
    end

    // Register file storage with synchronous clear
    always_ff @(posedge stg_clk) begin
        if (reset) begin
            regs_q <= '{default: {XLEN{1'b0}}};
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 never has pending writes
    assign cnt_arr_s[0] = CNT_ZERO;
    assign err_vec_s[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        wb_regfile_scoreboard_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .stg_clk   (stg_clk),
            .reset     (reset),
            .stg_ena   (stg_ena),
            .inc       (inc_s && (issue_rd == REG_IDX_W'(r))),
            .dec       (dec_s && (wb_rd == REG_IDX_W'(r))),
            .cnt       (cnt_arr_s[r]),
            .err_pulse (err_vec_s[r])
        );
    end

    // Read port 1: x0, then same-cycle writeback bypass, then stored value
    always_comb begin
        if (!is_arch_reg(rs1_addr)) begin
            rs1_data = {XLEN{1'b0}};
        end else if (wb_save && (wb_rd == rs1_addr)) begin
            rs1_data = wb_c;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    // Read port 2: x0, then same-cycle writeback bypass, then stored value
    always_comb begin
        if (!is_arch_reg(rs2_addr)) begin
            rs2_data = {XLEN{1'b0}};
        end else if (wb_save && (wb_rd == rs2_addr)) begin
            rs2_data = wb_c;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    // Decode hazard detection from the scoreboard
    always_comb begin
        busy1_s = operand_busy(rs1_addr, cnt_arr_s[rs1_addr], dec_s, wb_rd);
        busy2_s = operand_busy(rs2_addr, cnt_arr_s[rs2_addr], dec_s, wb_rd);
        stall_s = (rs1_used && busy1_s) || (rs2_used && busy2_s);
    end

    // Sticky error accumulation, frozen while the stage is disabled
    always_comb begin
        if (stg_ena) begin
            sb_error_d = sb_error_q || (|err_vec_s);
        end else begin
            sb_error_d = sb_error_q;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge stg_clk) begin
        if (reset) begin
            sb_error_q <= 1'b0;
        end else begin
            sb_error_q <= sb_error_d;
        end
    end

    assign stall    = stall_s;
    assign sb_error = sb_error_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: stimulus pushes expected port
// values into a queue, a negedge monitor pops and compares them.
module tb_wb_regfile_scoreboard;

    logic        stg_clk = 1'b0;
    logic        reset;
    logic        stg_ena;
    logic [4:0]  wb_rd;
    logic [31:0] wb_c;
    logic        wb_save;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_writes;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;
    logic        sb_error;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 stg_clk = ~stg_clk;

    wb_regfile_scoreboard dut (
        .stg_clk      (stg_clk),
        .reset        (reset),
        .stg_ena      (stg_ena),
        .wb_rd        (wb_rd),
        .wb_c         (wb_c),
        .wb_save      (wb_save),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_writes (issue_writes),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .stall        (stall),
        .sb_error     (sb_error)
    );

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor: compare every pending expectation against the live outputs
    always @(negedge stg_clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "rs1_data", rs1_data, e.r1);
            cmp(e.name, "rs2_data", rs2_data, e.r2);
            cmp(e.name, "stall", {31'd0, stall}, {31'd0, e.st});
            cmp(e.name, "sb_error", {31'd0, sb_error}, {31'd0, e.er});
        end
    end

    task automatic push(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                        input logic st, input logic er);
        exp_t e;
        e.name = nm; e.r1 = r1; e.r2 = r2; e.st = st; e.er = er;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stg_ena = 1'b1;
        wb_save = 1'b0; wb_rd = 5'd0; wb_c = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_writes = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] c);
        wb_save = 1'b1; wb_rd = rd; wb_c = c;
    endtask

    task automatic iss(input logic [4:0] rd);
        issue_valid = 1'b1; issue_rd = rd; issue_writes = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc(); cyc();

        // Reset state of all read indices
        for (int i = 0; i < 32; i++) begin
            idle();
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); rs1_used = 1'b1; rs2_used = 1'b1;
            push("reset_read", 32'd0, 32'd0, 1'b0, 1'b0);
            cyc();
        end

        // Build some state, then reset with the stage disabled
        idle(); wb(5'd10, 32'h0000_0055); cyc();
        idle(); iss(5'd11); wb(5'd12, 32'h0000_0077); cyc();
        idle(); rs1_addr = 5'd11; rs1_used = 1'b1; rs2_addr = 5'd12;
        push("pre_reset_state", 32'd0, 32'h0000_0077, 1'b1, 1'b1); cyc();
        idle(); reset = 1'b1; stg_ena = 1'b0; cyc();
        idle(); stg_ena = 1'b0; rs1_addr = 5'd11; rs1_used = 1'b1; rs2_addr = 5'd12;
        push("reset_noena_a", 32'd0, 32'd0, 1'b0, 1'b0); cyc();
        idle(); stg_ena = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd11; rs2_used = 1'b1;
        push("reset_noena_b", 32'd0, 32'd0, 1'b0, 1'b0); cyc();

        // Same-cycle bypass and persistence
        idle(); iss(5'd5); rs1_addr = 5'd5; rs1_used = 1'b1;
        push("issue5", 32'd0, 32'd0, 1'b0, 1'b0); cyc();
        idle(); wb(5'd5, 32'hDEAD_BEEF); rs1_addr = 5'd5; rs1_used = 1'b1;
        push("bypass5", 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd5; rs1_used = 1'b1;
        push("after_wr5", 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0); cyc();

        // x0 stays zero with and without bypass
        idle(); wb(5'd0, 32'h0000_1234); rs2_addr = 5'd5;
        push("x0_bypass", 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0); cyc();
        idle();
        push("x0_read", 32'd0, 32'd0, 1'b0, 1'b0); cyc();

        // Two writes in flight to x7; a stalled issue must not allocate
        idle(); iss(5'd7); cyc();
        idle(); iss(5'd7); cyc();
        idle(); iss(5'd7); rs1_addr = 5'd7; rs1_used = 1'b1; rs2_addr = 5'd7;
        push("rd7_stall", 32'd0, 32'd0, 1'b1, 1'b0); cyc();
        idle(); wb(5'd7, 32'h1111_1111); rs1_addr = 5'd7; rs2_addr = 5'd7; rs2_used = 1'b1;
        push("rd7_wb1", 32'h1111_1111, 32'h1111_1111, 1'b1, 1'b0); cyc();
        idle(); wb(5'd7, 32'h2222_2222); rs1_addr = 5'd7; rs2_addr = 5'd7;
        rs1_used = 1'b1; rs2_used = 1'b1;
        push("rd7_wb2", 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd7; rs2_addr = 5'd7; rs1_used = 1'b1; rs2_used = 1'b1;
        push("rd7_done", 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0); cyc();

        // Stage disabled: bypass live, no write, no count, no underflow
        idle(); stg_ena = 1'b0; wb(5'd4, 32'h0000_00AA); iss(5'd8); rs1_addr = 5'd4;
        push("noena_bypass", 32'h0000_00AA, 32'd0, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd4; rs2_addr = 5'd8; rs2_used = 1'b1;
        push("noena_no_write", 32'd0, 32'd0, 1'b0, 1'b0); cyc();

        // Simultaneous issue and writeback to x6 leaves the count at one
        idle(); iss(5'd6); cyc();
        idle(); iss(5'd6); wb(5'd6, 32'h0000_0066); rs1_addr = 5'd6;
        push("same_cycle_6", 32'h0000_0066, 32'd0, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd6; rs1_used = 1'b1;
        push("cnt6_still1", 32'h0000_0066, 32'd0, 1'b1, 1'b0); cyc();
        idle(); wb(5'd6, 32'h0000_0067); rs1_addr = 5'd6; rs1_used = 1'b1;
        push("cnt6_drain", 32'h0000_0067, 32'd0, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd6; rs1_used = 1'b1;
        push("cnt6_zero", 32'h0000_0067, 32'd0, 1'b0, 1'b0); cyc();

        // Overflow on x3: fourth issue flags and the count saturates at 3
        for (int k = 0; k < 3; k++) begin
            idle(); iss(5'd3); cyc();
        end
        idle(); iss(5'd3);
        push("ovf_issue4", 32'd0, 32'd0, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
        push("ovf_flag", 32'd0, 32'd0, 1'b1, 1'b1); cyc();
        idle(); wb(5'd3, 32'h0000_0031); rs1_addr = 5'd3; rs1_used = 1'b1;
        push("ovf_wb1", 32'h0000_0031, 32'd0, 1'b1, 1'b1); cyc();
        idle(); wb(5'd3, 32'h0000_0032); rs1_addr = 5'd3; rs1_used = 1'b1;
        push("ovf_wb2", 32'h0000_0032, 32'd0, 1'b1, 1'b1); cyc();
        idle(); wb(5'd3, 32'h0000_0033); rs1_addr = 5'd3; rs1_used = 1'b1;
        push("ovf_wb3", 32'h0000_0033, 32'd0, 1'b0, 1'b1); cyc();
        idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
        push("ovf_drained", 32'h0000_0033, 32'd0, 1'b0, 1'b1); cyc();

        // Reset clears the flag; then underflow on x9
        idle(); reset = 1'b1; cyc();
        idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
        push("reset2", 32'd0, 32'd0, 1'b0, 1'b0); cyc();
        idle(); wb(5'd9, 32'h0000_0099); rs1_addr = 5'd9; rs1_used = 1'b1;
        push("unf_wb", 32'h0000_0099, 32'd0, 1'b0, 1'b0); cyc();
        idle(); rs1_addr = 5'd9;
        push("unf_flag", 32'h0000_0099, 32'd0, 1'b0, 1'b1); cyc();
        idle(); stg_ena = 1'b0; rs2_addr = 5'd9;
        push("unf_sticky", 32'd0, 32'h0000_0099, 1'b0, 1'b1); cyc();

        // Reset mid-flight drops pending writes
        idle(); iss(5'd13); cyc();
        idle(); reset = 1'b1; cyc();
        idle(); rs1_addr = 5'd13; rs1_used = 1'b1;
        push("midflight_reset", 32'd0, 32'd0, 1'b0, 1'b0); cyc();

        idle();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            cyc();
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
